mem_arbiter: RTL and testbench

- Sits directly downstream of cpu_datapath's two memory ports: port A (instruction fetch, read-only) and port B (data, read/write).
- Merges both onto a single physical memory port (pmem_*) with round-robin arbitration.
- Latches the granted request for the whole transaction and routes the response back to the granted client only.
- Lets the pipeline use one shared memory or L2 while keeping the existing A/B handshake unchanged: request held high until resp.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter_control.sv | 70 +++++++
 rtl/mem_arbiter.sv | 82 ++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter slice.
//   lc3b_word      : 16-bit machine word used on address/data buses
//   lc3b_arb_state : arbiter FSM state, exported so debug logic and the
//                    bench can decode the arbiter's current phase
package mem_arbiter_pkg;

   localparam int LC3B_WORD_W = 16;

   typedef logic [LC3B_WORD_W-1:0] lc3b_word;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_SERVE_A = 2'd1,
      ARB_SERVE_B = 2'd2
   } lc3b_arb_state;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two CPU memory ports, the arbiter and the shared
// physical memory port.
//   Port A : read_a, address_a -> resp_a, rdata_a (instruction fetch)
//   Port B : read_b, write_b, wmask_b, address_b, wdata_b -> resp_b, rdata_b
//   pmem   : pmem_read/write/wmask/address/wdata -> pmem_resp, pmem_rdata
// Modports: slave = arbiter view, master = clients + memory view.
interface mem_arbiter_if #(
   parameter int WIDTH = 16
);
   logic             read_a;
   logic [WIDTH-1:0] address_a;
   logic             resp_a;
   logic [WIDTH-1:0] rdata_a;

   logic             read_b;
   logic             write_b;
   logic [1:0]       wmask_b;
   logic [WIDTH-1:0] address_b;
   logic [WIDTH-1:0] wdata_b;
   logic             resp_b;
   logic [WIDTH-1:0] rdata_b;

   logic             pmem_read;
   logic             pmem_write;
   logic [1:0]       pmem_wmask;
   logic [WIDTH-1:0] pmem_address;
   logic [WIDTH-1:0] pmem_wdata;
   logic             pmem_resp;
   logic [WIDTH-1:0] pmem_rdata;

   modport slave (
      input  read_a, address_a,
      output resp_a, rdata_a,
      input  read_b, write_b, wmask_b, address_b, wdata_b,
      output resp_b, rdata_b,
      output pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
      input  pmem_resp, pmem_rdata
   );

   modport master (
      output read_a, address_a,
      input  resp_a, rdata_a,
      output read_b, write_b, wmask_b, address_b, wdata_b,
      input  resp_b, rdata_b,
      input  pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
      output pmem_resp, pmem_rdata
   );
endinterface

// File: rtl/mem_arbiter_control.sv
// Arbitration FSM for mem_arbiter: decides which port is granted, remembers
// the last grant for round-robin tie breaking, and tracks the serve phase.
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_req_a, i_req_b   : pending requests from port A / port B
//   i_pmem_resp        : memory completion strobe
//   o_grant_a/b        : one-cycle grant pulse, also the latch enable
//   o_serve_a/b        : high while the memory access for that port runs
//   o_state            : current FSM state for debug
module mem_arbiter_control
   import mem_arbiter_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_req_a,
   input  logic          i_req_b,
   input  logic          i_pmem_resp,
   output logic          o_grant_a,
   output logic          o_grant_b,
   output logic          o_serve_a,
   output logic          o_serve_b,
   output lc3b_arb_state o_state
);

   localparam logic [1:0] S_IDLE    = 2'(ARB_IDLE);
   localparam logic [1:0] S_SERVE_A = 2'(ARB_SERVE_A);
   localparam logic [1:0] S_SERVE_B = 2'(ARB_SERVE_B);

   logic [1:0] r_state;
   logic [1:0] w_next;
   logic       r_last_grant;   // 0 = A served last, 1 = B served last
   logic       w_idle;

   assign w_idle = (r_state == S_IDLE);

   // On a tie the port that was not served last wins; after reset that is B.
   assign o_grant_a = w_idle & i_req_a & (~i_req_b |  r_last_grant);
   assign o_grant_b = w_idle & i_req_b & (~i_req_a | ~r_last_grant);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (o_grant_a)      w_next = S_SERVE_A;
            else if (o_grant_b) w_next = S_SERVE_B;
         end
         S_SERVE_A, S_SERVE_B: begin
            // Always return through IDLE so a held request is re-arbitrated
            // as a fresh request instead of being served twice.
            if (i_pmem_resp) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b0;
      end else begin
         r_state <= w_next;
         if (o_grant_a)      r_last_grant <= 1'b0;
         else if (o_grant_b) r_last_grant <= 1'b1;
      end
   end

   assign o_serve_a = (r_state == S_SERVE_A);
   assign o_serve_b = (r_state == S_SERVE_B);
   assign o_state   = lc3b_arb_state'(r_state);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter. Port A (fetch, read-only) and port B
// (data, read/write) share one physical memory port with round-robin
// arbitration. The granted request is latched for the whole transaction and
// the completion is routed back only to the granted port.
//   clk, reset   : clock, synchronous active-high reset
//   bus          : client and memory signals (slave modport)
//   o_dbg_state  : current arbiter state for debug
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int WIDTH = LC3B_WORD_W
)(
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus,
   output lc3b_arb_state o_dbg_state
);

   logic             w_req_b;
   logic             w_grant_a;
   logic             w_grant_b;
   logic             w_serve_a;
   logic             w_serve_b;
   logic             w_serve;

   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] r_wdata;
   logic [1:0]       r_wmask;
   logic             r_write;

   assign w_req_b = bus.read_b | bus.write_b;

   mem_arbiter_control u_control (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_req_a     (bus.read_a),
      .i_req_b     (w_req_b),
      .i_pmem_resp (bus.pmem_resp),
      .o_grant_a   (w_grant_a),
      .o_grant_b   (w_grant_b),
      .o_serve_a   (w_serve_a),
      .o_serve_b   (w_serve_b),
      .o_state     (o_dbg_state)
   );

   // Request latch: captured on the grant cycle so clients may change or
   // drop their inputs while the memory access is in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_wmask <= 2'b00;
         r_write <= 1'b0;
      end else if (w_grant_a) begin
         r_addr  <= bus.address_a;
         r_wdata <= '0;
         r_wmask <= 2'b11;
         r_write <= 1'b0;
      end else if (w_grant_b) begin
         r_addr  <= bus.address_b;
         r_wdata <= bus.wdata_b;
         r_wmask <= bus.wmask_b;
         r_write <= bus.write_b;   // write wins when read_b and write_b are both set
      end
   end

   // Strobes and completions are masked during reset so an in-flight access
   // is abandoned immediately.
   assign w_serve = (w_serve_a | w_serve_b) & ~reset;

   assign bus.pmem_read    = w_serve & ~r_write;
   assign bus.pmem_write   = w_serve &  r_write;
   assign bus.pmem_address = r_addr;
   assign bus.pmem_wdata   = r_wdata;
   assign bus.pmem_wmask   = r_wmask;

   assign bus.resp_a  = w_serve_a & bus.pmem_resp & ~reset;
   assign bus.resp_b  = w_serve_b & bus.pmem_resp & ~reset;
   assign bus.rdata_a = bus.pmem_rdata;
   assign bus.rdata_b = bus.pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   typedef struct {
      int       port;
      bit       wr;
      lc3b_word addr;
      lc3b_word wdata;
      logic [1:0] wmask;
   } txn_t;

   typedef struct {
      int       port;
      lc3b_word rdata;
   } rsp_t;

   logic          clk;
   logic          reset;
   lc3b_arb_state dbg_state;

   mem_arbiter_if #(.WIDTH(16)) bus ();

   mem_arbiter #(.WIDTH(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   txn_t sb_req[$];
   rsp_t sb_resp[$];
   int   obs[$];

   // reference model state
   bit m_busy     = 0;
   int m_port     = 0;
   int m_last     = 0;   // port served most recently; A after reset so B wins first tie
   int m_lat      = 0;
   int lat_force  = -1;
   int rdata_force = -1;
   bit junk_en    = 0;

   bit exp_busy = 0;
   bit mon_en   = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   // ---------------- monitor / scoreboard ----------------
   txn_t cur;
   bit   in_txn = 0;
   always @(negedge clk) begin
      if (!mon_en) begin
         in_txn = 0;
      end else begin
         rsp_t r;
         chk("strobe", 32'(bus.pmem_read | bus.pmem_write), 32'(exp_busy));
         chk("rw_excl", 32'(bus.pmem_read & bus.pmem_write), 0);
         if (exp_busy && !in_txn && sb_req.size() > 0) begin
            cur = sb_req.pop_front();
            in_txn = 1;
         end
         if (in_txn) begin
            chk("pmem_read",  32'(bus.pmem_read),  32'(!cur.wr));
            chk("pmem_write", 32'(bus.pmem_write), 32'(cur.wr));
            chk("pmem_addr",  32'(bus.pmem_address), 32'(cur.addr));
            chk("pmem_wdata", 32'(bus.pmem_wdata),   32'(cur.wdata));
            chk("pmem_wmask", 32'(bus.pmem_wmask),   32'(cur.wmask));
            chk("state", 32'(dbg_state), 32'(cur.port == 1 ? ARB_SERVE_B : ARB_SERVE_A));
         end else if (!exp_busy) begin
            chk("state_idle", 32'(dbg_state), 32'(ARB_IDLE));
         end
         if (bus.resp_a) obs.push_back(0);
         if (bus.resp_b) obs.push_back(1);
         if (sb_resp.size() > 0 || bus.resp_a || bus.resp_b) begin
            if (sb_resp.size() == 0) begin
               chk("unexpected_resp", {bus.resp_a, bus.resp_b}, 0);
            end else begin
               r = sb_resp.pop_front();
               chk("resp_a", 32'(bus.resp_a), 32'(r.port == 0));
               chk("resp_b", 32'(bus.resp_b), 32'(r.port == 1));
               chk("rdata", 32'(r.port == 0 ? bus.rdata_a : bus.rdata_b), 32'(r.rdata));
               in_txn = 0;
            end
         end
      end
   end

   // ---------------- reference model: one clock cycle ----------------
   task automatic tick(output int rport);
      int g;
      bit resp_now;
      bit ra, rb;
      rport = -1;
      resp_now = 0;
      g = -1;
      exp_busy = m_busy;
      bus.pmem_rdata = 16'($urandom);
      if (m_busy) begin
         if (m_lat == 0) begin
            if (rdata_force >= 0) bus.pmem_rdata = 16'(rdata_force);
            bus.pmem_resp = 1'b1;
            sb_resp.push_back('{port: m_port, rdata: bus.pmem_rdata});
            resp_now = 1;
            rport = m_port;
         end else begin
            bus.pmem_resp = 1'b0;
            m_lat--;
         end
      end else begin
         bus.pmem_resp = junk_en && ($urandom_range(0, 4) == 0);
         ra = bus.read_a;
         rb = bus.read_b | bus.write_b;
         if (ra && rb)  g = (m_last == 0) ? 1 : 0;
         else if (ra)   g = 0;
         else if (rb)   g = 1;
         if (g == 0)
            sb_req.push_back('{port: 0, wr: 1'b0, addr: bus.address_a, wdata: 16'h0, wmask: 2'b11});
         else if (g == 1)
            sb_req.push_back('{port: 1, wr: bus.write_b, addr: bus.address_b,
                               wdata: bus.wdata_b, wmask: bus.wmask_b});
      end
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b0;
      if (resp_now) m_busy = 0;
      if (g >= 0) begin
         m_busy = 1;
         m_port = g;
         m_last = g;
         m_lat  = (lat_force >= 0) ? lat_force : $urandom_range(0, 3);
      end
   endtask

   task automatic drop(input int port);
      if (port == 0) bus.read_a = 1'b0;
      else begin
         bus.read_b  = 1'b0;
         bus.write_b = 1'b0;
      end
   endtask

   task automatic run_until(input int port);
      int rp;
      bit done = 0;
      for (int i = 0; i < 30 && !done; i++) begin
         tick(rp);
         if (rp == port) done = 1;
      end
      chk("resp_wait", 32'(done), 1);
      drop(port);
   endtask

   task automatic clear_inputs();
      bus.read_a = 0; bus.address_a = 0;
      bus.read_b = 0; bus.write_b = 0; bus.wmask_b = 0;
      bus.address_b = 0; bus.wdata_b = 0;
      bus.pmem_resp = 0; bus.pmem_rdata = 0;
   endtask

   task automatic do_reset();
      mon_en = 0;
      clear_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      m_busy = 0; m_last = 0; exp_busy = 0;
      sb_req.delete(); sb_resp.delete(); obs.delete();
      @(negedge clk);
      chk("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
      chk("rst_pmem_read", 32'(bus.pmem_read), 0);
      chk("rst_pmem_write", 32'(bus.pmem_write), 0);
      chk("rst_resp", {bus.resp_a, bus.resp_b}, 0);
      chk("rst_addr", 32'(bus.pmem_address), 0);
      chk("rst_wdata", 32'(bus.pmem_wdata), 0);
      chk("rst_wmask", 32'(bus.pmem_wmask), 0);
      @(posedge clk);
      #1;
      mon_en = 1;
   endtask

   task automatic rand_inputs(input int last_rp);
      if (last_rp == 0 && $urandom_range(0, 1) == 0) drop(0);
      if (last_rp == 1 && $urandom_range(0, 1) == 0) drop(1);
      if (!bus.read_a) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.read_a = 1'b1;
            bus.address_a = 16'($urandom);
         end
      end else if ($urandom_range(0, 19) == 0) begin
         bus.read_a = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
         bus.address_a = 16'($urandom);
      end
      if (!(bus.read_b || bus.write_b)) begin
         if ($urandom_range(0, 3) == 0) begin
            int op;
            op = $urandom_range(1, 3);
            bus.read_b    = op[0];
            bus.write_b   = op[1];
            bus.address_b = 16'($urandom);
            bus.wdata_b   = 16'($urandom);
            bus.wmask_b   = 2'($urandom);
         end
      end else if ($urandom_range(0, 29) == 0) begin
         drop(1);
      end else if ($urandom_range(0, 9) == 0) begin
         bus.address_b = 16'($urandom);
         bus.wdata_b   = 16'($urandom);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rp;
      int n_rand;
      int exp_ord[4];
      exp_ord = '{1, 0, 1, 0};
      reset = 1'b1;
      clear_inputs();
      do_reset();

      // reset during an in-flight write, with a late memory completion
      mon_en = 0;
      bus.write_b = 1; bus.address_b = 16'h0123; bus.wdata_b = 16'h5555; bus.wmask_b = 2'b10;
      @(posedge clk); #1;
      @(negedge clk);
      chk("pre_rst_write", 32'(bus.pmem_write), 1);
      reset = 1'b1;
      bus.pmem_resp = 1'b1;
      #1;
      chk("in_rst_resp_b", 32'(bus.resp_b), 0);
      chk("in_rst_write", 32'(bus.pmem_write), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      bus.write_b = 0;
      @(negedge clk);
      chk("post_rst_write", 32'(bus.pmem_write), 0);
      chk("post_rst_resp_b", 32'(bus.resp_b), 0);
      chk("post_rst_state", 32'(dbg_state), 32'(ARB_IDLE));
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;
      @(negedge clk);
      chk("late_resp_ignored", 32'(dbg_state), 32'(ARB_IDLE));
      @(posedge clk); #1;
      m_busy = 0; m_last = 0; exp_busy = 0;
      mon_en = 1;

      // port A read, 3-cycle memory
      bus.read_a = 1; bus.address_a = 16'h0040;
      lat_force = 2; rdata_force = 16'h1234;
      run_until(0);
      rdata_force = -1;

      // port B write
      bus.write_b = 1; bus.address_b = 16'h0102; bus.wdata_b = 16'hBEEF; bus.wmask_b = 2'b01;
      lat_force = 0;
      run_until(1);
      tick(rp);

      // address change during SERVE_B must not reach memory
      bus.read_b = 1; bus.address_b = 16'h0200;
      lat_force = 3;
      tick(rp);
      bus.address_b = 16'h0300;
      run_until(1);

      // read_b and write_b together act as a write
      bus.read_b = 1; bus.write_b = 1; bus.address_b = 16'h0010; bus.wdata_b = 16'hA5A5;
      lat_force = 1;
      run_until(1);
      tick(rp);

      // contention from reset: B, A, B, A
      do_reset();
      bus.read_a = 1; bus.address_a = 16'h1000;
      bus.read_b = 1; bus.address_b = 16'h2000;
      lat_force = 0;
      n_rand = 0;
      for (int i = 0; i < 40 && n_rand < 4; i++) begin
         tick(rp);
         if (rp >= 0) n_rand++;
      end
      drop(0); drop(1);
      tick(rp); tick(rp);
      for (int i = 0; i < 4; i++)
         chk("grant_order", (obs.size() > i) ? 32'(obs[i]) : 32'hFFFF_FFFF, 32'(exp_ord[i]));

      // randomized traffic
      do_reset();
      junk_en = 1;
      lat_force = -1;
      n_rand = 0;
      rp = -1;
      for (int c = 0; c < 4000 && n_rand < 200; c++) begin
         rand_inputs(rp);
         tick(rp);
         if (rp >= 0) n_rand++;
      end
      drop(0); drop(1);
      junk_en = 0;
      repeat (8) tick(rp);
      chk("req_queue_drained", 32'(sb_req.size()), 0);
      chk("resp_queue_drained", 32'(sb_resp.size()), 0);

      mon_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
